// File: rtl/ring_core.sv
// Ring node for the bhiv multicore: ring slot pass/strip logic plus an engine
// that reads each private cache line, adds CORENUM to every word and writes it back.
module ring_core #(
   parameter int CORENUM = 1,
   parameter int TSIZE   = 4,
   parameter int SSIZE   = 4,
   parameter int NBLINES = 7,
   parameter int NBWORDS = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [TSIZE-1:0]   slot_type_in,
   input  logic [SSIZE-1:0]   slot_source_in,
   input  logic [31:0]        slot_data_in,
   output logic [TSIZE-1:0]   slot_type_out,
   output logic [SSIZE-1:0]   slot_source_out,
   output logic [31:0]        slot_data_out,
   input  logic [SSIZE-1:0]   mc_dest,
   input  logic [NBWORDS-1:0] mc_count,
   input  logic [31:0]        mc_data
);

   localparam int NWORDS      = 2 ** NBWORDS;
   localparam int NBCACHELINE = 30 - NBWORDS;

   localparam logic [TSIZE-1:0] T_NULL  = TSIZE'(0);
   localparam logic [TSIZE-1:0] T_TOKEN = TSIZE'(1);
   localparam logic [TSIZE-1:0] T_ADDR  = TSIZE'(2);
   localparam logic [TSIZE-1:0] T_WDATA = TSIZE'(3);

   localparam logic [SSIZE-1:0]       CORE_ID   = SSIZE'(CORENUM);
   localparam logic [NBCACHELINE-1:0] LINE_BASE = NBCACHELINE'(CORENUM) << NBLINES;
   localparam logic [NBCACHELINE-1:0] LINE_END  = '1;
   localparam logic [NBWORDS-1:0]     LAST_WORD = NBWORDS'(NWORDS - 1);
   localparam logic [NBLINES-1:0]     LAST_OFF  = '1;

   typedef enum logic [3:0] {
      RD_REQ, RD_REL, RD_WAIT, MOD, WR_REQ, WR_DATA, WR_REL, NEXT, FIN, FIN_REL, HALT
   } state_t;

   state_t                  r_state;
   state_t                  w_nextState;
   logic [NBLINES-1:0]      r_offset;
   logic [NBWORDS-1:0]      r_wordIdx;
   logic [31:0]             r_buf [NWORDS];
   logic                    w_tokenIn;
   logic                    w_mcHit;
   logic [NBCACHELINE-1:0]  w_line;

   function automatic logic [31:0] addrPayload(input logic [NBCACHELINE-1:0] line, input logic rw);
      logic [31:0] p;
      p = '0;
      p[NBCACHELINE-1:0] = line;
      p[NBCACHELINE] = rw;
      return p;
   endfunction

   // Reset must never capture the token, even though the state already reads RD_REQ.
   assign w_tokenIn = !reset && (slot_type_in == T_TOKEN);
   assign w_mcHit   = (mc_dest == CORE_ID);
   assign w_line    = LINE_BASE + NBCACHELINE'(r_offset);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= RD_REQ;
      else       r_state <= w_nextState;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_offset  <= '0;
         r_wordIdx <= '0;
      end else begin
         if (r_state == WR_DATA) r_wordIdx <= r_wordIdx + NBWORDS'(1);
         if (r_state == NEXT && r_offset != LAST_OFF) r_offset <= r_offset + NBLINES'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == RD_WAIT && w_mcHit) begin
         r_buf[mc_count] <= mc_data;
      end else if (r_state == MOD) begin
         for (int k = 0; k < NWORDS; k++) r_buf[k] <= r_buf[k] + 32'(CORENUM);
      end
   end

   // Emission overrides stripping, which overrides pass-through.
   always_comb begin
      w_nextState     = r_state;
      slot_type_out   = slot_type_in;
      slot_source_out = slot_source_in;
      slot_data_out   = slot_data_in;
      if ((slot_type_in == T_ADDR || slot_type_in == T_WDATA) && slot_source_in == CORE_ID) begin
         slot_type_out   = T_NULL;
         slot_source_out = '0;
         slot_data_out   = '0;
      end
      case (r_state)
         RD_REQ: if (w_tokenIn) begin
            slot_type_out   = T_ADDR;
            slot_source_out = CORE_ID;
            slot_data_out   = addrPayload(w_line, 1'b0);
            w_nextState     = RD_REL;
         end
         RD_WAIT: if (w_mcHit && mc_count == LAST_WORD) w_nextState = MOD;
         MOD: w_nextState = WR_REQ;
         WR_REQ: if (w_tokenIn) begin
            slot_type_out   = T_ADDR;
            slot_source_out = CORE_ID;
            slot_data_out   = addrPayload(w_line, 1'b1);
            w_nextState     = WR_DATA;
         end
         WR_DATA: begin
            slot_type_out   = T_WDATA;
            slot_source_out = CORE_ID;
            slot_data_out   = r_buf[r_wordIdx];
            if (r_wordIdx == LAST_WORD) w_nextState = WR_REL;
         end
         NEXT: w_nextState = (r_offset == LAST_OFF) ? FIN : RD_REQ;
         FIN: if (w_tokenIn) begin
            slot_type_out   = T_ADDR;
            slot_source_out = CORE_ID;
            slot_data_out   = addrPayload(LINE_END, 1'b0);
            w_nextState     = FIN_REL;
         end
         RD_REL, WR_REL, FIN_REL: begin
            slot_type_out   = T_TOKEN;
            slot_source_out = '0;
            slot_data_out   = '0;
            w_nextState     = (r_state == RD_REL) ? RD_WAIT :
                              (r_state == WR_REL) ? NEXT : HALT;
         end
         HALT: w_nextState = HALT;
         default: w_nextState = RD_REQ;
      endcase
   end

endmodule

// File: tb/tb_ring_core.sv
// Bench for ring_core as core 2: a vector table for ring pass/strip/grab behaviour,
// then hand sequences walking the whole private region, the finish marker and a mid-burst reset.
module tb_ring_core;

   localparam logic [3:0] NUL = 4'd0;
   localparam logic [3:0] TOK = 4'd1;
   localparam logic [3:0] ADR = 4'd2;
   localparam logic [3:0] WDT = 4'd3;

   logic        clk;
   logic        reset;
   logic [3:0]  slotTypeIn, slotSrcIn, slotTypeOut, slotSrcOut;
   logic [31:0] slotDataIn, slotDataOut;
   logic [3:0]  mcDest;
   logic [2:0]  mcCount;
   logic [31:0] mcData;

   typedef struct {
      logic        rst;
      logic [3:0]  sType;
      logic [3:0]  sSrc;
      logic [31:0] sData;
      logic [3:0]  mcDest;
      logic [2:0]  mcCount;
      logic [31:0] mcData;
      logic [3:0]  eType;
      logic [3:0]  eSrc;
      logic [31:0] eData;
   } vec_t;

   typedef struct {
      int          id;
      logic [3:0]  t;
      logic [3:0]  s;
      logic [31:0] d;
   } exp_t;

   vec_t tbl[$];
   exp_t expQ[$];
   int   checks;
   int   failures;
   int   stepId;

   ring_core #(.CORENUM(2), .TSIZE(4), .SSIZE(4), .NBLINES(7), .NBWORDS(3)) dut (
      .clk(clk),
      .reset(reset),
      .slot_type_in(slotTypeIn),
      .slot_source_in(slotSrcIn),
      .slot_data_in(slotDataIn),
      .slot_type_out(slotTypeOut),
      .slot_source_out(slotSrcOut),
      .slot_data_out(slotDataOut),
      .mc_dest(mcDest),
      .mc_count(mcCount),
      .mc_data(mcData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic rst, input logic [3:0] st, input logic [3:0] ss,
                               input logic [31:0] sd, input logic [3:0] md, input logic [2:0] mc,
                               input logic [31:0] mdat, input logic [3:0] et, input logic [3:0] es,
                               input logic [31:0] ed);
      vec_t v;
      v.rst = rst; v.sType = st; v.sSrc = ss; v.sData = sd;
      v.mcDest = md; v.mcCount = mc; v.mcData = mdat;
      v.eType = et; v.eSrc = es; v.eData = ed;
      return v;
   endfunction

   function automatic vec_t rv(input logic rst, input logic [3:0] st, input logic [3:0] ss,
                               input logic [31:0] sd, input logic [3:0] et, input logic [3:0] es,
                               input logic [31:0] ed);
      return mk(rst, st, ss, sd, 4'd0, 3'd0, 32'd0, et, es, ed);
   endfunction

   task automatic applyStimulus(input vec_t v);
      exp_t e;
      @(posedge clk);
      #1;
      reset      = v.rst;
      slotTypeIn = v.sType;
      slotSrcIn  = v.sSrc;
      slotDataIn = v.sData;
      mcDest     = v.mcDest;
      mcCount    = v.mcCount;
      mcData     = v.mcData;
      e.id = stepId; e.t = v.eType; e.s = v.eSrc; e.d = v.eData;
      expQ.push_back(e);
      stepId++;
   endtask

   task automatic checkOutput();
      exp_t e;
      @(negedge clk);
      e = expQ.pop_front();
      checks++;
      if (slotTypeOut !== e.t || slotSrcOut !== e.s || slotDataOut !== e.d) begin
         failures++;
         $display("[TB] FAIL step%0d: got type=%0d src=%0d data=%h, want type=%0d src=%0d data=%h",
                  e.id, slotTypeOut, slotSrcOut, slotDataOut, e.t, e.s, e.d);
      end
   endtask

   task automatic run(input vec_t v);
      applyStimulus(v);
      checkOutput();
   endtask

   // Engine sits in RD_WAIT for line 0x100+off; deliver a line and check the writeback.
   task automatic doLine(input int off, input bit readNext);
      logic [31:0] words [8];
      for (int k = 0; k < 8; k++) begin
         words[k] = $urandom;
         run(mk(0, NUL, 0, 0, 4'd2, 3'(k), words[k], NUL, 0, 0));
      end
      run(rv(0, NUL, 0, 0, NUL, 0, 0));
      run(rv(0, TOK, 0, 0, ADR, 2, 32'h0800_0000 | (32'h100 + 32'(off))));
      for (int k = 0; k < 8; k++) run(rv(0, NUL, 0, 0, WDT, 2, words[k] + 32'd2));
      run(rv(0, NUL, 0, 0, TOK, 0, 0));
      run(rv(0, NUL, 0, 0, NUL, 0, 0));
      if (readNext) begin
         run(rv(0, TOK, 0, 0, ADR, 2, 32'h100 + 32'(off) + 32'd1));
         run(rv(0, NUL, 0, 0, TOK, 0, 0));
      end
   endtask

   initial begin
      checks = 0; failures = 0; stepId = 0;
      reset = 1'b1;
      slotTypeIn = NUL; slotSrcIn = 0; slotDataIn = 0;
      mcDest = 0; mcCount = 0; mcData = 0;

      tbl.push_back(rv(1, TOK, 0, 0,          TOK, 0, 0));
      tbl.push_back(rv(1, ADR, 2, 32'h55,     NUL, 0, 0));
      tbl.push_back(rv(1, WDT, 3, 32'h77,     WDT, 3, 32'h77));
      tbl.push_back(rv(0, NUL, 5, 32'hABC,    NUL, 5, 32'hABC));
      tbl.push_back(rv(0, ADR, 3, 32'h123,    ADR, 3, 32'h123));
      tbl.push_back(rv(0, WDT, 2, 32'h456,    NUL, 0, 0));
      tbl.push_back(rv(0, TOK, 0, 0,          ADR, 2, 32'h100));
      tbl.push_back(rv(0, NUL, 0, 0,          TOK, 0, 0));
      tbl.push_back(rv(0, TOK, 0, 0,          TOK, 0, 0));
      tbl.push_back(rv(0, ADR, 2, 32'h100,    NUL, 0, 0));
      tbl.push_back(mk(0, TOK, 0, 0, 4'd1, 3'd7, 32'h999, TOK, 0, 0));
      tbl.push_back(rv(0, TOK, 0, 0,          TOK, 0, 0));
      tbl.push_back(rv(0, TOK, 0, 0,          TOK, 0, 0));
      for (int k = 0; k < 8; k++) tbl.push_back(mk(0, NUL, 0, 0, 4'd2, 3'(k), 32'(10 + k), NUL, 0, 0));
      tbl.push_back(rv(0, TOK, 0, 0,          TOK, 0, 0));
      tbl.push_back(rv(0, NUL, 0, 0,          NUL, 0, 0));
      tbl.push_back(rv(0, TOK, 0, 0,          ADR, 2, 32'h0800_0100));
      for (int k = 0; k < 8; k++) begin
         if (k == 3) tbl.push_back(rv(0, ADR, 2, 32'h0800_0100, WDT, 2, 32'(12 + k)));
         else        tbl.push_back(rv(0, NUL, 0, 0,             WDT, 2, 32'(12 + k)));
      end
      tbl.push_back(rv(0, NUL, 0, 0,          TOK, 0, 0));
      tbl.push_back(rv(0, TOK, 0, 0,          TOK, 0, 0));
      tbl.push_back(rv(0, TOK, 0, 0,          ADR, 2, 32'h101));
      tbl.push_back(rv(0, NUL, 0, 0,          TOK, 0, 0));

      for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

      for (int off = 1; off < 128; off++) doLine(off, off != 127);

      run(rv(0, TOK, 0, 0, ADR, 2, 32'h07FF_FFFF));
      run(rv(0, NUL, 0, 0, TOK, 0, 0));
      for (int i = 0; i < 4; i++) run(rv(0, TOK, 0, 0, TOK, 0, 0));
      run(mk(0, TOK, 0, 0, 4'd2, 3'd7, 32'h1234, TOK, 0, 0));
      run(rv(0, TOK, 0, 0, TOK, 0, 0));
      run(rv(0, ADR, 2, 32'h07FF_FFFF, NUL, 0, 0));

      run(rv(1, NUL, 0, 0, NUL, 0, 0));
      run(rv(1, TOK, 0, 0, TOK, 0, 0));
      run(rv(0, TOK, 0, 0, ADR, 2, 32'h100));
      run(rv(0, NUL, 0, 0, TOK, 0, 0));
      for (int k = 0; k < 8; k++) run(mk(0, NUL, 0, 0, 4'd2, 3'(k), 32'(100 + k), NUL, 0, 0));
      run(rv(0, NUL, 0, 0, NUL, 0, 0));
      run(rv(0, TOK, 0, 0, ADR, 2, 32'h0800_0100));
      for (int k = 0; k < 3; k++) run(rv(0, NUL, 0, 0, WDT, 2, 32'(102 + k)));
      run(rv(1, NUL, 0, 0, NUL, 0, 0));
      run(rv(1, TOK, 0, 0, TOK, 0, 0));
      run(rv(0, NUL, 0, 0, NUL, 0, 0));
      run(rv(0, TOK, 0, 0, ADR, 2, 32'h100));
      run(rv(0, NUL, 0, 0, TOK, 0, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
